tick_scheduler: RTL and testbench



---
 rtl/tick_scheduler.sv | 233 +++++++++++++++++++++++
 tb/tb_tick_scheduler.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_scheduler.sv
// tick_scheduler: multi-channel timer scheduler sharing one prescaled time base.
// A free-running prescaler emits a one-cycle tick every DIV clocks. Each tick
// starts an N_CH-cycle scan that steps one channel per cycle through a single
// shared decrementer. Expired channels post pending events, which are handed
// to the consumer one at a time in round-robin order over valid/ready.
module tick_scheduler #(
    parameter int DIV   = 50000000,
    parameter int N_CH  = 4,
    parameter int CNT_W = 16,
    parameter int CH_W  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic             cfg_reload,
    output logic             tick,
    output logic             evt_valid,
    output logic [CH_W-1:0]  evt_ch,
    input  logic             evt_ready,
    output logic [N_CH-1:0]  active,
    output logic [N_CH-1:0]  overrun
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Prescaler
    logic [PW-1:0]    presc_q, presc_d;
    logic             tick_q, tick_d;

    // Scan FSM
    state_t           state_q, state_d;
    logic [CH_W-1:0]  idx_q, idx_d;
    logic             scan_en;

    // Per-channel timer state
    logic [CNT_W-1:0] cnt_q    [N_CH];
    logic [CNT_W-1:0] cnt_d    [N_CH];
    logic [CNT_W-1:0] period_q [N_CH];
    logic [CNT_W-1:0] period_d [N_CH];
    logic [N_CH-1:0]  reload_q, reload_d;
    logic [N_CH-1:0]  active_q, active_d;
    logic [N_CH-1:0]  pending_q, pending_d;
    logic [N_CH-1:0]  overrun_q, overrun_d;

    // Event output
    logic             evt_valid_q, evt_valid_d;
    logic [CH_W-1:0]  evt_ch_q, evt_ch_d;
    logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic             rr_found;
    logic [CH_W-1:0]  rr_next;
    logic [CH_W-1:0]  rr_cand;

    logic             cfg_fire;
    logic             evt_accept;

    // Prescaler next state: wrap at DIV-1 and register the tick one cycle later
    always_comb begin
        tick_d  = (presc_q == PW'(DIV - 1));
        presc_d = tick_d ? '0 : presc_q + PW'(1);
    end

    // Prescaler and tick registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments on every flop so all registers
            // update from the same pre-edge values regardless of block order.
            presc_q <= presc_d;
            tick_q  <= tick_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // FSM next state: a tick starts a scan at channel 0; the last channel ends it
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (tick_q) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                idx_d = idx_q + CH_W'(1);
                if (idx_q == CH_W'(N_CH - 1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: config is blocked in the tick cycle and throughout the scan
    always_comb begin
        cfg_ready = (state_q == IDLE) && !tick_q;
        scan_en   = (state_q == SCAN);
    end

    // Round-robin search: first pending channel at or after rr_ptr, wrapping
    always_comb begin
        rr_found = 1'b0;
        rr_next  = rr_ptr_q;
        rr_cand  = '0;
        for (int k = 0; k < N_CH; k++) begin
            rr_cand = rr_ptr_q + CH_W'(k);
            if (!rr_found && pending_q[rr_cand]) begin
                rr_found = 1'b1;
                rr_next  = rr_cand;
            end
        end
    end

    // Channel datapath: config accept, scan step and event hand-off
    always_comb begin
        cnt_d       = cnt_q;
        period_d    = period_q;
        reload_d    = reload_q;
        active_d    = active_q;
        pending_d   = pending_q;
        overrun_d   = overrun_q;
        evt_valid_d = evt_valid_q;
        evt_ch_d    = evt_ch_q;
        rr_ptr_d    = rr_ptr_q;

        cfg_fire   = cfg_valid && cfg_ready;
        evt_accept = evt_valid_q && evt_ready;

        // Event hand-off; a new event is only offered from an idle output
        if (evt_accept) begin
            pending_d[evt_ch_q] = 1'b0;
            rr_ptr_d            = evt_ch_q + CH_W'(1);
            evt_valid_d         = 1'b0;
        end else if (!evt_valid_q && rr_found) begin
            evt_valid_d = 1'b1;
            evt_ch_d    = rr_next;
        end

        // Config only happens in IDLE, so it never collides with the scan step
        if (cfg_fire) begin
            overrun_d[cfg_ch] = 1'b0;
            if (cfg_period != '0) begin
                period_d[cfg_ch] = cfg_period;
                cnt_d[cfg_ch]    = cfg_period;
                reload_d[cfg_ch] = cfg_reload;
                active_d[cfg_ch] = 1'b1;
            end else begin
                cnt_d[cfg_ch]    = '0;
                active_d[cfg_ch] = 1'b0;
            end
        end

        // Scan step for the channel under the shared decrementer. The pending
        // set is applied after the accept clear so a same-cycle set wins, and
        // an event consumed this cycle does not count as an overrun.
        if (scan_en && active_q[idx_q]) begin
            if (cnt_q[idx_q] == CNT_W'(1)) begin
                if (pending_q[idx_q] && !(evt_accept && (evt_ch_q == idx_q))) begin
                    overrun_d[idx_q] = 1'b1;
                end
                pending_d[idx_q] = 1'b1;
                if (reload_q[idx_q]) begin
                    cnt_d[idx_q] = period_q[idx_q];
                end else begin
                    cnt_d[idx_q]    = '0;
                    active_d[idx_q] = 1'b0;
                end
            end else begin
                cnt_d[idx_q] = cnt_q[idx_q] - CNT_W'(1);
            end
        end
    end

    // Channel and event registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the counter/period arrays are reset explicitly; reset
            // must leave every channel disarmed with known state, so they
            // are real flops, not a RAM.
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]    <= '0;
                period_q[i] <= '0;
            end
            reload_q    <= '0;
            active_q    <= '0;
            pending_q   <= '0;
            overrun_q   <= '0;
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            reload_q    <= reload_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            evt_valid_q <= evt_valid_d;
            evt_ch_q    <= evt_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign tick      = tick_q;
    assign evt_valid = evt_valid_q;
    assign evt_ch    = evt_ch_q;
    assign active    = active_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Testbench for tick_scheduler (DIV=10, N_CH=4, CNT_W=8).
// Expected event channels go into a queue as stimulus is applied; a monitor
// pops and compares on every accepted event.
module tb_tick_scheduler;

    localparam int DIV   = 10;
    localparam int N_CH  = 4;
    localparam int CNT_W = 8;
    localparam int CH_W  = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch = '0;
    logic [CNT_W-1:0] cfg_period = '0;
    logic             cfg_reload = 1'b0;
    logic             tick;
    logic             evt_valid;
    logic [CH_W-1:0]  evt_ch;
    logic             evt_ready = 1'b1;
    logic [N_CH-1:0]  active;
    logic [N_CH-1:0]  overrun;

    tick_scheduler #(
        .DIV   (DIV),
        .N_CH  (N_CH),
        .CNT_W (CNT_W),
        .CH_W  (CH_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_reload (cfg_reload),
        .tick       (tick),
        .evt_valid  (evt_valid),
        .evt_ch     (evt_ch),
        .evt_ready  (evt_ready),
        .active     (active),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_pass   = 0;
    int n_total  = 0;
    int evt_seen = 0;
    logic [CH_W-1:0] exp_q [$];
    logic [CH_W-1:0] exp_ch;

    typedef struct {
        logic [CH_W-1:0]  ch;
        logic [CNT_W-1:0] period;
        logic             reload;
        int               ticks;
        int               exp_events;
        logic             exp_active;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Scoreboard monitor: compare each accepted event against the queue head
    always @(negedge clk) begin
        if (rst_n && evt_valid && evt_ready) begin
            evt_seen++;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL evt_unexpected: got ch %0d, expected no event", evt_ch);
            end else begin
                exp_ch = exp_q.pop_front();
                check("evt_ch", 32'(evt_ch), 32'(exp_ch));
            end
        end
    end

    // Hold reset for two edges, then release just after a rising edge
    task automatic do_reset();
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        evt_ready = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Wait for the next tick, counting rising edges; bounded
    task automatic wait_tick(output int cyc);
        cyc = 0;
        while (cyc < 4 * DIV) begin
            @(posedge clk); #1;
            cyc++;
            if (tick) break;
        end
        if (!tick) begin
            n_total++;
            $display("FAIL tick_timeout: got no tick, expected one within %0d cycles", 4 * DIV);
        end
    endtask

    // Let n ticks elapse, then let the scan and event hand-off settle
    task automatic run_ticks(input int n);
        int c;
        repeat (n) wait_tick(c);
        repeat (8) @(posedge clk);
        #1;
    endtask

    // Present one config request and hold it until accepted; bounded
    task automatic do_cfg(input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] period,
                          input logic reload);
        int w;
        cfg_valid  = 1'b1;
        cfg_ch     = ch;
        cfg_period = period;
        cfg_reload = reload;
        w = 0;
        while (!cfg_ready && w < 4 * DIV) begin
            @(posedge clk); #1;
            w++;
        end
        if (!cfg_ready) begin
            n_total++;
            $display("FAIL cfg_timeout: got cfg_ready=0, expected 1 within %0d cycles", 4 * DIV);
        end
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[5];
        int c, base, n_busy;

        // Single-channel vectors
        vecs[0] = '{ch: 2'd1, period: 8'd3, reload: 1'b0, ticks: 5, exp_events: 1, exp_active: 1'b0};
        vecs[1] = '{ch: 2'd2, period: 8'd1, reload: 1'b0, ticks: 2, exp_events: 1, exp_active: 1'b0};
        vecs[2] = '{ch: 2'd0, period: 8'd2, reload: 1'b1, ticks: 4, exp_events: 2, exp_active: 1'b1};
        vecs[3] = '{ch: 2'd3, period: 8'd0, reload: 1'b1, ticks: 2, exp_events: 0, exp_active: 1'b0};
        vecs[4] = '{ch: 2'd1, period: 8'd3, reload: 1'b1, ticks: 2, exp_events: 0, exp_active: 1'b1};

        // Reset state, then free-running ticks with no config
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_evt_valid", 32'(evt_valid), 32'd0);
        check("rst_evt_ch", 32'(evt_ch), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        wait_tick(c);
        check("tick1_gap", 32'(c), 32'(DIV));
        check("tick1_width_ready", 32'(cfg_ready), 32'd0);
        wait_tick(c);
        check("tick2_gap", 32'(c), 32'(DIV));
        wait_tick(c);
        check("tick3_gap", 32'(c), 32'(DIV));
        check("idle_evt_valid", 32'(evt_valid), 32'd0);
        check("idle_active", 32'(active), 32'd0);

        // Table-driven single-channel runs
        for (int v = 0; v < 5; v++) begin
            do_reset();
            do_cfg(vecs[v].ch, vecs[v].period, vecs[v].reload);
            for (int e = 0; e < vecs[v].exp_events; e++) exp_q.push_back(vecs[v].ch);
            base = evt_seen;
            run_ticks(vecs[v].ticks);
            check($sformatf("vec%0d_events", v), 32'(evt_seen - base), 32'(vecs[v].exp_events));
            check($sformatf("vec%0d_active", v), 32'(active[vecs[v].ch]), 32'(vecs[v].exp_active));
            check($sformatf("vec%0d_queue", v), 32'(exp_q.size()), 32'd0);
        end

        // Two periodic channels: order on shared ticks is ch0 then ch2
        do_reset();
        do_cfg(2'd0, 8'd1, 1'b1);
        do_cfg(2'd2, 8'd2, 1'b1);
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd2);
        base = evt_seen;
        run_ticks(4);
        check("rr_events", 32'(evt_seen - base), 32'd6);
        check("rr_queue", 32'(exp_q.size()), 32'd0);
        check("rr_active", 32'(active), 32'b0101);

        // Stalled consumer: held event and sticky overrun, cleared by reconfig
        do_reset();
        evt_ready = 1'b0;
        do_cfg(2'd3, 8'd1, 1'b1);
        wait_tick(c);
        repeat (6) @(posedge clk);
        #1;
        check("stall1_valid", 32'(evt_valid), 32'd1);
        check("stall1_ch", 32'(evt_ch), 32'd3);
        check("stall1_overrun", 32'(overrun), 32'd0);
        wait_tick(c);
        repeat (6) @(posedge clk);
        #1;
        check("stall2_overrun", 32'(overrun), 32'b1000);
        check("stall2_ch", 32'(evt_ch), 32'd3);
        wait_tick(c);
        repeat (6) @(posedge clk);
        #1;
        check("stall3_valid", 32'(evt_valid), 32'd1);
        check("stall3_ch", 32'(evt_ch), 32'd3);
        do_cfg(2'd3, 8'd0, 1'b0);
        check("reconf_overrun", 32'(overrun), 32'd0);
        check("reconf_active", 32'(active), 32'd0);
        check("reconf_valid", 32'(evt_valid), 32'd1);
        exp_q.push_back(2'd3);
        evt_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("drain_queue", 32'(exp_q.size()), 32'd0);
        check("drain_valid", 32'(evt_valid), 32'd0);

        // Config presented in the tick cycle waits through the scan
        do_reset();
        wait_tick(c);
        cfg_valid  = 1'b1;
        cfg_ch     = 2'd1;
        cfg_period = 8'd2;
        cfg_reload = 1'b0;
        n_busy = 0;
        while (!cfg_ready && n_busy < 20) begin
            n_busy++;
            @(posedge clk); #1;
        end
        check("busy_cycles", 32'(n_busy), 32'(N_CH + 1));
        check("busy_not_taken", 32'(active), 32'd0);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        check("late_cfg_active", 32'(active), 32'b0010);
        base = evt_seen;
        run_ticks(1);
        check("late_cfg_no_evt", 32'(evt_seen - base), 32'd0);
        check("late_cfg_still_active", 32'(active), 32'b0010);
        exp_q.push_back(2'd1);
        run_ticks(1);
        check("late_cfg_evt", 32'(evt_seen - base), 32'd1);
        check("late_cfg_done", 32'(active), 32'd0);

        // Reset asserted mid-scan with a pending event
        do_reset();
        evt_ready = 1'b0;
        do_cfg(2'd0, 8'd1, 1'b1);
        check("pre_rst_active", 32'(active), 32'b0001);
        wait_tick(c);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_tick", 32'(tick), 32'd0);
        check("midrst_cfg_ready", 32'(cfg_ready), 32'd1);
        check("midrst_evt_valid", 32'(evt_valid), 32'd0);
        check("midrst_evt_ch", 32'(evt_ch), 32'd0);
        check("midrst_active", 32'(active), 32'd0);
        check("midrst_overrun", 32'(overrun), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_tick(c);
        check("post_rst_gap", 32'(c), 32'(DIV));
        repeat (6) @(posedge clk);
        #1;
        check("post_rst_no_evt", 32'(evt_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
